// File: rtl/ofc_pulse_height.sv
// ofc_pulse_height: pedestal-subtracted NTAPS-tap optimal-filter pulse height with saturation.
// Latency: trigger in cycle T -> ph_valid in cycle T+NTAPS; PulseHeight/pileup held until the next ph_valid.
// No backpressure: one sample per clk; a trigger in DONE or before the pedestal is primed is dropped (trig_drop).
module ofc_pulse_height #(
    parameter int DATA_W    = 14,
    parameter int NTAPS     = 5,
    parameter int COEF_W    = 24,
    parameter int FRAC_BITS = 20,
    parameter int OUT_W     = 16,
    parameter int PED_LOG2  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       triggerIn,
    input  logic [DATA_W-1:0]          signal,
    input  logic                       coef_wr,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       busy,
    output logic                       ph_valid,
    output logic signed [OUT_W-1:0]    PulseHeight,
    output logic                       pileup,
    output logic                       trig_drop
);
    localparam int AW     = $clog2(NTAPS);
    localparam int NPED   = 2 ** PED_LOG2;
    localparam int PROD_W = DATA_W + 1 + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(NTAPS);
    localparam int SUM_W  = DATA_W + PED_LOG2;
    localparam logic signed [ACC_W-1:0] PH_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] PH_MIN = ~PH_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                    state;
    logic [DATA_W-1:0]         ped_buf [NPED];
    logic [PED_LOG2:0]         fill_cnt;
    logic                      ped_ready;
    logic [SUM_W-1:0]          ped_sum;
    logic [DATA_W-1:0]         ped_now;
    logic [DATA_W-1:0]         ped_q;
    logic signed [COEF_W-1:0]  coef [NTAPS];
    logic [AW-1:0]             tap_cnt;
    logic signed [ACC_W-1:0]   acc;
    logic                      pile_lat;

    logic                      idle;
    logic [DATA_W-1:0]         ped_sel;
    logic signed [COEF_W-1:0]  coef_sel;
    logic signed [DATA_W:0]    diff;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_base;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   acc_shr;
    logic signed [OUT_W-1:0]   ph_sat;

    assign ped_ready = (fill_cnt == (PED_LOG2 + 1)'(NPED));
    assign idle      = (state == IDLE);

    // Pedestal: truncating mean of the buffered pre-trigger samples.
    always_comb begin
        ped_sum = '0;
        for (int i = 0; i < NPED; i++) begin
            ped_sum = ped_sum + SUM_W'(ped_buf[i]);
        end
        ped_now = ped_sum[SUM_W-1:PED_LOG2];
    end

    // Tap datapath; in IDLE the trigger cycle uses the fresh pedestal, tap 0 and a cleared accumulator.
    always_comb begin
        ped_sel  = idle ? ped_now : ped_q;
        coef_sel = idle ? coef[0] : coef[tap_cnt];
        diff     = $signed({1'b0, signal}) - $signed({1'b0, ped_sel});
        prod     = PROD_W'(diff) * PROD_W'(coef_sel);
        acc_base = idle ? '0 : acc;
        acc_next = acc_base + ACC_W'(prod);
        acc_shr  = acc_next >>> FRAC_BITS;
        if (acc_shr > PH_MAX) begin
            ph_sat = PH_MAX[OUT_W-1:0];
        end else if (acc_shr < PH_MIN) begin
            ph_sat = PH_MIN[OUT_W-1:0];
        end else begin
            ph_sat = acc_shr[OUT_W-1:0];
        end
    end

    // Pedestal history shifts only while idle; it must refill after every capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPED; i++) begin
                ped_buf[i] <= '0;
            end
            fill_cnt <= '0;
        end else if (state == IDLE) begin
            ped_buf[0] <= signal;
            for (int i = 1; i < NPED; i++) begin
                ped_buf[i] <= ped_buf[i-1];
            end
            if (!ped_ready) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end else if (state == DONE) begin
            fill_cnt <= '0;
        end
    end

    // Coefficient file: writable only while idle, out-of-range taps ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (idle && coef_wr && (int'(coef_addr) < NTAPS)) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Capture FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            tap_cnt     <= '0;
            ped_q       <= '0;
            pile_lat    <= 1'b0;
            busy        <= 1'b0;
            ph_valid    <= 1'b0;
            PulseHeight <= '0;
            pileup      <= 1'b0;
            trig_drop   <= 1'b0;
        end else begin
            ph_valid  <= 1'b0;
            trig_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (triggerIn) begin
                        if (ped_ready) begin
                            ped_q    <= ped_now;
                            acc      <= acc_next;
                            tap_cnt  <= AW'(1);
                            pile_lat <= 1'b0;
                            busy     <= 1'b1;
                            state    <= ACCUM;
                        end else begin
                            trig_drop <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    acc     <= acc_next;
                    tap_cnt <= tap_cnt + 1'b1;
                    if (triggerIn) begin
                        pile_lat <= 1'b1;
                    end
                    if (tap_cnt == AW'(NTAPS - 1)) begin
                        ph_valid    <= 1'b1;
                        PulseHeight <= ph_sat;
                        pileup      <= pile_lat | triggerIn;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (triggerIn) begin
                        trig_drop <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ofc_pulse_height.sv
// Bench for ofc_pulse_height: directed plan scenarios plus randomized captures against an arithmetic model.
// Each capture: pedestal = floor(mean of 4 pre-trigger samples), result = floor(sum((s-ped)*c) / 2^20), saturated.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled at the same point.
module tb_ofc_pulse_height;
    localparam int NTAPS     = 5;
    localparam int FRAC_BITS = 20;

    logic               clk = 1'b0;
    logic               reset;
    logic               triggerIn;
    logic [13:0]        signal;
    logic               coef_wr;
    logic [2:0]         coef_addr;
    logic signed [23:0] coef_data;
    logic               busy;
    logic               ph_valid;
    logic signed [15:0] PulseHeight;
    logic               pileup;
    logic               trig_drop;

    int checks   = 0;
    int failures = 0;
    int mcoef  [NTAPS];
    int base_s [4];
    int tap_s  [NTAPS];
    bit wr_in_accum = 1'b0;

    ofc_pulse_height dut (
        .clk(clk), .reset(reset), .triggerIn(triggerIn), .signal(signal),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .busy(busy), .ph_valid(ph_valid), .PulseHeight(PulseHeight),
        .pileup(pileup), .trig_drop(trig_drop)
    );

    always #5 clk = ~clk;

    function automatic longint model_ph();
        longint ped, acc, r;
        ped = (longint'(base_s[0]) + base_s[1] + base_s[2] + base_s[3]) / 4;
        acc = 0;
        for (int k = 0; k < NTAPS; k++) acc += (longint'(tap_s[k]) - ped) * longint'(mcoef[k]);
        r = acc >>> FRAC_BITS;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic drive(input logic trig, input int sig);
        triggerIn = trig;
        signal    = 14'(sig);
        @(posedge clk); #1;
    endtask

    task automatic write_coef(input int addr, input int val);
        triggerIn = 1'b0;
        coef_wr   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = 24'(val);
        @(posedge clk); #1;
        coef_wr = 1'b0;
        if (addr < NTAPS) mcoef[addr] = val;
    endtask

    task automatic set_coefs(input int c0, input int c1, input int c2, input int c3, input int c4);
        drive(1'b0, 0);
        write_coef(0, c0); write_coef(1, c1); write_coef(2, c2); write_coef(3, c3); write_coef(4, c4);
    endtask

    task automatic rand_taps();
        for (int k = 0; k < NTAPS; k++) tap_s[k] = int'($urandom_range(0, 16383));
    endtask

    // Drives gap + pedestal + one pulse; returns what was seen in cycle T+NTAPS.
    task automatic run_capture(output bit early, output logic vld, output logic signed [15:0] ph,
                               output logic pl);
        early = 1'b0;
        drive(1'b0, base_s[0]);
        for (int i = 0; i < 4; i++) drive(1'b0, base_s[i]);
        drive(1'b1, tap_s[0]);
        if (ph_valid !== 1'b0 || busy !== 1'b1) early = 1'b1;
        for (int k = 1; k < NTAPS; k++) begin
            if (wr_in_accum) begin
                coef_wr = 1'b1; coef_addr = 3'(k - 1); coef_data = 24'h5A5A5A;
            end
            drive(1'b0, tap_s[k]);
            if (busy !== 1'b1) early = 1'b1;
            if (k < NTAPS - 1 && ph_valid !== 1'b0) early = 1'b1;
        end
        coef_wr = 1'b0;
        vld = ph_valid; ph = PulseHeight; pl = pileup;
    endtask

    task automatic test_reset();
        bit e; logic v; logic signed [15:0] p; logic l; longint exp;
        reset = 1'b1; triggerIn = 1'b1; coef_wr = 1'b1; coef_addr = 3'd0; coef_data = 24'd123; signal = 14'd50;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({busy, ph_valid, pileup, trig_drop} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b required 0000", {busy, ph_valid, pileup, trig_drop});
        end
        checks++;
        if (PulseHeight !== 16'sd0) begin
            failures++; $display("FAIL reset_ph: got %0d required 0", PulseHeight);
        end
        reset = 1'b0; coef_wr = 1'b0;
        for (int k = 0; k < NTAPS; k++) mcoef[k] = 0;
        drive(1'b1, 100);
        checks++;
        if (trig_drop !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL unprimed_drop: got drop=%b busy=%b required drop=1 busy=0", trig_drop, busy);
        end
        drive(1'b0, 100);
        checks++;
        if (trig_drop !== 1'b0) begin
            failures++; $display("FAIL drop_one_cycle: got %b required 0", trig_drop);
        end
        base_s = '{100, 100, 100, 100}; rand_taps();
        exp = model_ph();
        run_capture(e, v, p, l);
        checks++;
        if (e !== 1'b0 || v !== 1'b1 || p !== 16'(exp)) begin
            failures++; $display("FAIL cleared_coefs: got early=%b vld=%b ph=%0d required 0/1/%0d", e, v, p, exp);
        end
    endtask

    task automatic test_basic();
        bit e; logic v; logic signed [15:0] p; logic l; longint exp;
        set_coefs(1048576, 1048576, 1048576, 1048576, 1048576);
        base_s = '{100, 100, 100, 100}; tap_s = '{100, 200, 300, 200, 100};
        exp = model_ph();
        run_capture(e, v, p, l);
        checks++;
        if (e !== 1'b0 || v !== 1'b1) begin
            failures++; $display("FAIL basic_latency: got early=%b vld=%b required 0/1", e, v);
        end
        checks++;
        if (p !== 16'(exp) || l !== 1'b0) begin
            failures++; $display("FAIL basic_ph: got ph=%0d pileup=%b required %0d/0", p, l, exp);
        end
        drive(1'b0, 100);
        checks++;
        if (ph_valid !== 1'b0 || busy !== 1'b0 || PulseHeight !== 16'(exp)) begin
            failures++; $display("FAIL basic_hold: got vld=%b busy=%b ph=%0d required 0/0/%0d", ph_valid, busy, PulseHeight, exp);
        end
    endtask

    task automatic test_negative();
        bit e; logic v; logic signed [15:0] p; logic l; longint exp;
        set_coefs(-1048576, -1048576, -1048576, -1048576, -1048576);
        base_s = '{100, 100, 100, 100}; tap_s = '{100, 200, 300, 200, 100};
        exp = model_ph();
        run_capture(e, v, p, l);
        checks++;
        if (v !== 1'b1 || p !== 16'(exp)) begin
            failures++; $display("FAIL negative_ph: got vld=%b ph=%0d required 1/%0d", v, p, exp);
        end
    endtask

    task automatic test_fraction();
        bit e; logic v; logic signed [15:0] p; logic l; longint exp;
        set_coefs(524288, 0, 0, 0, 0);
        base_s = '{98, 99, 101, 102}; rand_taps(); tap_s[0] = 301;
        exp = model_ph();
        run_capture(e, v, p, l);
        checks++;
        if (v !== 1'b1 || p !== 16'(exp)) begin
            failures++; $display("FAIL fraction_ph: got vld=%b ph=%0d required 1/%0d", v, p, exp);
        end
    endtask

    task automatic test_saturation();
        bit e; logic v; logic signed [15:0] p; logic l; longint exp;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) set_coefs(8388607, 8388607, 8388607, 8388607, 8388607);
            else           set_coefs(-8388608, -8388608, -8388608, -8388608, -8388608);
            base_s = '{0, 0, 0, 0}; tap_s = '{16383, 16383, 16383, 16383, 16383};
            exp = model_ph();
            run_capture(e, v, p, l);
            checks++;
            if (v !== 1'b1 || p !== 16'(exp)) begin
                failures++; $display("FAIL saturation_%0d: got vld=%b ph=%0d required 1/%0d", pass, v, p, exp);
            end
        end
    endtask

    task automatic test_addr_ignore();
        bit e; logic v; logic signed [15:0] p; logic l; longint exp;
        set_coefs(262144, -524288, 1048576, 786432, -131072);
        write_coef(5, 7340032); write_coef(6, -7340032); write_coef(7, 4194304);
        base_s = '{500, 510, 520, 530}; rand_taps();
        exp = model_ph();
        run_capture(e, v, p, l);
        checks++;
        if (v !== 1'b1 || p !== 16'(exp)) begin
            failures++; $display("FAIL addr_ignore: got vld=%b ph=%0d required 1/%0d", v, p, exp);
        end
    endtask

    task automatic test_random();
        bit e; logic v; logic signed [15:0] p; logic l; longint exp;
        int c [NTAPS];
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < NTAPS; k++) begin
                if ($urandom_range(0, 1) == 0) c[k] = int'($urandom_range(0, 4194303)) - 2097152;
                else                           c[k] = int'($urandom_range(0, 16777215)) - 8388608;
            end
            set_coefs(c[0], c[1], c[2], c[3], c[4]);
            for (int i = 0; i < 4; i++) base_s[i] = int'($urandom_range(0, 16383));
            rand_taps();
            exp = model_ph();
            run_capture(e, v, p, l);
            checks++;
            if (e !== 1'b0 || v !== 1'b1 || p !== 16'(exp) || l !== 1'b0) begin
                failures++; $display("FAIL random_%0d: got early=%b vld=%b ph=%0d pl=%b required 0/1/%0d/0", it, e, v, p, l, exp);
            end
        end
    endtask

    task automatic test_pileup_drop();
        bit e; logic v; logic signed [15:0] p; logic l; longint exp;
        set_coefs(1048576, 1048576, 1048576, 1048576, 1048576);
        base_s = '{200, 200, 200, 200}; rand_taps();
        exp = model_ph();
        drive(1'b0, 200);
        for (int i = 0; i < 4; i++) drive(1'b0, base_s[i]);
        drive(1'b1, tap_s[0]);
        drive(1'b0, tap_s[1]);
        drive(1'b1, tap_s[2]);
        checks++;
        if (trig_drop !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL retrig_accum: got drop=%b busy=%b required 0/1", trig_drop, busy);
        end
        drive(1'b0, tap_s[3]);
        drive(1'b0, tap_s[4]);
        checks++;
        if (ph_valid !== 1'b1 || pileup !== 1'b1 || PulseHeight !== 16'(exp)) begin
            failures++; $display("FAIL pileup_result: got vld=%b pl=%b ph=%0d required 1/1/%0d", ph_valid, pileup, PulseHeight, exp);
        end
        drive(1'b1, 300);
        checks++;
        if (trig_drop !== 1'b1 || ph_valid !== 1'b0) begin
            failures++; $display("FAIL done_drop: got drop=%b vld=%b required 1/0", trig_drop, ph_valid);
        end
        drive(1'b0, 300);
        checks++;
        if (trig_drop !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL after_done: got drop=%b busy=%b required 0/0", trig_drop, busy);
        end
        drive(1'b1, 300);
        checks++;
        if (trig_drop !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL refill_drop: got drop=%b busy=%b required 1/0", trig_drop, busy);
        end
        rand_taps();
        exp = model_ph();
        run_capture(e, v, p, l);
        checks++;
        if (v !== 1'b1 || l !== 1'b0 || p !== 16'(exp)) begin
            failures++; $display("FAIL pileup_clear: got vld=%b pl=%b ph=%0d required 1/0/%0d", v, l, p, exp);
        end
    endtask

    task automatic test_write_busy();
        bit e; logic v; logic signed [15:0] p; logic l; longint exp;
        set_coefs(1048576, 524288, -262144, 2097152, -1048576);
        base_s = '{1000, 1004, 996, 1000}; rand_taps();
        exp = model_ph();
        wr_in_accum = 1'b1;
        run_capture(e, v, p, l);
        wr_in_accum = 1'b0;
        checks++;
        if (v !== 1'b1 || p !== 16'(exp)) begin
            failures++; $display("FAIL write_busy_same: got vld=%b ph=%0d required 1/%0d", v, p, exp);
        end
        rand_taps();
        exp = model_ph();
        run_capture(e, v, p, l);
        checks++;
        if (v !== 1'b1 || p !== 16'(exp)) begin
            failures++; $display("FAIL write_busy_next: got vld=%b ph=%0d required 1/%0d", v, p, exp);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        set_coefs(1048576, 1048576, 1048576, 1048576, 1048576);
        base_s = '{100, 100, 100, 100}; rand_taps();
        drive(1'b0, 100);
        for (int i = 0; i < 4; i++) drive(1'b0, base_s[i]);
        drive(1'b1, tap_s[0]);
        drive(1'b0, tap_s[1]);
        reset = 1'b1;
        drive(1'b0, tap_s[2]);
        checks++;
        if (busy !== 1'b0 || ph_valid !== 1'b0) begin
            failures++; $display("FAIL reset_abort: got busy=%b vld=%b required 0/0", busy, ph_valid);
        end
        reset = 1'b0;
        for (int k = 0; k < NTAPS; k++) mcoef[k] = 0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, tap_s[i % NTAPS]);
            if (ph_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL reset_no_valid: got ph_valid seen=%b required 0", seen);
        end
    endtask

    initial begin
        reset = 1'b1; triggerIn = 1'b0; signal = '0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
        test_reset();
        test_basic();
        test_negative();
        test_fraction();
        test_saturation();
        test_addr_ignore();
        test_random();
        test_pileup_drop();
        test_reset_mid();
        test_write_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ofc_pulse_height.md
Name: ofc_pulse_height

Overview:
- Parametrised optimal-filter (OFC) pulse-height calculator; next generation of the fixed 5-tap calculator.
- Sits between the ADC sample stream and the UART/readout path.
- On trigger, subtracts an averaged pre-trigger pedestal from NTAPS consecutive samples and forms a signed fixed-point weighted sum.
- Generalised over the fixed block: runtime-loadable signed coefficients, multi-sample pedestal, saturation, valid strobe, pileup/drop flags.

Parameters:
- DATA_W, 14: ADC sample width (unsigned).
- NTAPS, 5: number of filter taps / samples per pulse (2..16).
- COEF_W, 24: signed coefficient width (two's complement).
- FRAC_BITS, 20: coefficient fractional bits; 1.0 = 2^FRAC_BITS.
- OUT_W, 16: signed pulse-height output width.
- PED_LOG2, 2: pedestal = mean of 2^PED_LOG2 pre-trigger samples.

Ports:
- clk  in  1  sample clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- triggerIn  in  1  trigger; sample on `signal` in the same cycle is tap 0.
- signal  in  DATA_W  ADC sample, one per clk.
- coef_wr  in  1  coefficient write strobe.
- coef_addr  in  clog2(NTAPS)  tap index to write.
- coef_data  in  COEF_W  signed coefficient value.
- busy  out  1  high in ACCUM and DONE.
- ph_valid  out  1  one-cycle strobe; result fields valid.
- PulseHeight  out  OUT_W  signed, saturated result; held until next ph_valid.
- pileup  out  1  qualifies ph_valid; a trigger arrived during that capture.
- trig_drop  out  1  one-cycle pulse when a trigger is ignored.

Behaviour:
- Reset:
  - All outputs 0 and state IDLE.
  - Coefficients, pedestal buffer, fill counter and accumulator cleared.
  - Reset during ACCUM/DONE aborts the capture; no ph_valid is issued.
- Pedestal buffer:
  - Shift register of the last 2^PED_LOG2 samples, updated every IDLE cycle.
  - Frozen in ACCUM and DONE.
  - Fill counter saturates at 2^PED_LOG2. It is cleared by reset and on entry to IDLE from DONE.
  - ped_ready = fill counter full.
- States:
  - IDLE:
    - triggerIn && ped_ready: latch pedestal = (sum of buffer) >> PED_LOG2 (truncating); clear acc; accumulate tap 0 in this cycle; tap_cnt <= 1; go to ACCUM.
    - triggerIn && !ped_ready: trig_drop = 1 next cycle; stay in IDLE.
  - ACCUM:
    - Each cycle accumulate tap tap_cnt; increment tap_cnt.
    - After tap NTAPS-1 is accumulated, go to DONE.
  - DONE:
    - ph_valid = 1; PulseHeight and pileup registered.
    - Return to IDLE next cycle.
- Latency: trigger at cycle T; taps are samples T..T+NTAPS-1; ph_valid asserted at cycle T+NTAPS.
- Arithmetic:
  - diff = signal − pedestal, signed DATA_W+1.
  - prod = diff × coef[k], signed.
  - acc is signed, DATA_W+1+COEF_W+clog2(NTAPS) bits, with no internal overflow.
  - Result = acc >>> FRAC_BITS (arithmetic shift, floor), then saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Retrigger:
  - triggerIn in ACCUM sets the pileup latch for the current capture; no trig_drop.
  - triggerIn in DONE: trig_drop pulse, trigger ignored.
- Coefficients:
  - coef_wr applies only in IDLE and is visible from the next cycle.
  - coef_wr while busy is ignored.
  - coef_addr ≥ NTAPS is ignored.
  - A write and an accepted trigger in the same IDLE cycle: the write is applied; the capture uses the old coefficients for tap 0 only if addr = 0. Tests must avoid relying on this case.

Test Plan:
1. Pedestal and basic sum.
   - Stimulus: reset; load all 5 coefs = 1048576; signal 100 for 6 cycles; trigger with samples 100,200,300,200,100.
   - Response: ph_valid at T+5; PulseHeight = 400; pileup = 0.
2. Negative coefficients.
   - Stimulus: same as 1 with all coefs = −1048576.
   - Response: PulseHeight = −400.
3. Pedestal averaging and fractions.
   - Stimulus: pre-trigger samples 98,99,101,102; coef0 = 524288 (0.5), others 0; tap0 = 301.
   - Response: pedestal 100; PulseHeight = 100.
4. Saturation.
   - Stimulus: baseline 0; all coefs = 8388607; five taps of 16383.
   - Response: PulseHeight = 32767. Repeat with coefs = −8388608: PulseHeight = −32768.
5. Pileup and drop.
   - Stimulus: trigger at T and T+2; then a trigger at T+5 (DONE); then a trigger at T+7 (buffer refilling).
   - Response: one ph_valid at T+5 with pileup = 1; trig_drop pulses at T+6 and T+8.
6. Reset mid-capture and write while busy.
   - Stimulus: reset at T+2.
   - Response: no ph_valid; busy = 0 at T+3.
   - Stimulus: coef_wr during ACCUM.
   - Response: coefficients unchanged; next result matches old coefficients.
